// File: rtl/board_io_if.sv
// Bus port bundle for board_io_ctrl: request/write strobes, address, write
// data, and the registered acknowledge with its read data.
interface board_io_if;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O controller. It synchronises and debounces the switch and button
// inputs, drives the LED outputs from a register, and raises a level
// interrupt on the selected edges of the debounced inputs.
module board_io_ctrl #(
  parameter int               IN_W        = 16,
  parameter int               OUT_W       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter int               DEB_CYCLES  = 65536,
  parameter logic [OUT_W-1:0] OUT_RST     = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IN_W-1:0]  pin_i,
  output logic [OUT_W-1:0] pin_o,
  output logic             irq_o,
  board_io_if.slave        bus
);

  localparam int            PW      = $clog2(DEB_CYCLES);
  localparam logic [PW-1:0] PRE_MAX = PW'(DEB_CYCLES - 1);

  logic [IN_W-1:0]  sync_q [SYNC_STAGES];
  logic [PW-1:0]    pre_q, pre_d;
  logic [IN_W-1:0]  deb_q, deb_d, prv_q, prv_d;
  logic [IN_W-1:0]  en_q, en_d, rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             irq_q, irq_d, ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             tick;
  logic [IN_W-1:0]  s, eq, pend_set, w1c;
  logic             wr;
  logic [2:0]       word;

  // Synchroniser chain for the raw asynchronous pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Next-state logic for the prescaler, the debouncer, the registers and the bus response.
  always_comb begin
    s        = sync_q[SYNC_STAGES-1];
    tick     = (pre_q == PRE_MAX);
    pre_d    = tick ? '0 : pre_q + PW'(1);

    // A bit is accepted only when two consecutive tick samples agree.
    eq       = ~(s ^ prv_q);
    prv_d    = tick ? s : prv_q;
    deb_d    = tick ? ((eq & s) | (~eq & deb_q)) : deb_q;

    wr       = bus.req & bus.we;
    word     = bus.addr[4:2];

    out_d    = out_q;
    en_d     = en_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    w1c      = '0;
    if (wr) begin
      case (word)
        3'd1: out_d  = bus.wdata[OUT_W-1:0];
        3'd2: en_d   = bus.wdata[IN_W-1:0];
        3'd3: rise_d = bus.wdata[IN_W-1:0];
        3'd4: fall_d = bus.wdata[IN_W-1:0];
        3'd5: w1c    = bus.wdata[IN_W-1:0];
        default: ;
      endcase
    end

    // The clear mask is applied before the new edges are ORed in, so a new edge on a bit wins over a clear of that bit.
    pend_set = (deb_d & ~deb_q & rise_q) | (~deb_d & deb_q & fall_q);
    pend_d   = (pend_q & ~w1c) | pend_set;
    irq_d    = |(pend_d & en_d);

    ack_d    = bus.req;
    rdata_d  = '0;
    if (bus.req && !bus.we) begin
      case (word)
        3'd0: rdata_d = 32'(deb_q);
        3'd1: rdata_d = 32'(out_q);
        3'd2: rdata_d = 32'(en_q);
        3'd3: rdata_d = 32'(rise_q);
        3'd4: rdata_d = 32'(fall_q);
        3'd5: rdata_d = 32'(pend_q);
        default: rdata_d = '0;
      endcase
    end
  end

  // State registers; reset overrides any bus access in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q   <= '0;
      deb_q   <= '0;
      prv_q   <= '0;
      out_q   <= OUT_RST;
      en_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      pre_q   <= pre_d;
      deb_q   <= deb_d;
      prv_q   <= prv_d;
      out_q   <= out_d;
      en_q    <= en_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign pin_o     = out_q;
  assign irq_o     = irq_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl with DEB_CYCLES=4 and OUT_RST=16'hA5A5. Bus
// requests push the expected read data into a queue, and a monitor pops and
// compares that data whenever an acknowledge appears.
module tb_board_io_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pin = '0;
  logic [15:0] pin_o;
  logic        irq;

  board_io_if bus ();

  board_io_ctrl #(
    .IN_W(16), .OUT_W(16), .SYNC_STAGES(2), .DEB_CYCLES(4), .OUT_RST(16'hA5A5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pin_i(pin), .pin_o(pin_o), .irq_o(irq), .bus(bus)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset. The prescaler value in a cycle is cyc % 4.
  int cyc;
  always @(posedge clk) if (rst) cyc <= 0; else cyc <= cyc + 1;

  logic [31:0] exp_q [$];
  logic [31:0] e;
  int n_cmp = 0;
  int n_fail = 0;
  int c, t2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every acknowledge must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("rdata", bus.rdata, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_op(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] ex);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    exp_q.push_back(ex);
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ex);
    bus_op(1'b0, a, 32'h0, ex);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_op(1'b1, a, d, 32'h0);
  endtask

  // If a pin changes in cycle cc, the synchronised value appears at cc+2.
  // The first tick at or after that cycle loads prv. The next tick, four
  // cycles later, accepts the value into deb.
  function automatic int accept_cycle(input int cc);
    int t1;
    t1 = cc + 2;
    while (t1 % 4 != 3) t1++;
    return t1 + 4;
  endfunction

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pin_o", pin_o, 32'hA5A5);
    check("rst_irq", irq, 0);
    check("rst_ack", bus.ack, 0);
    rst = 1'b0;

    rd(5'h00, 32'h0);
    rd(5'h04, 32'h0000_A5A5);
    rd(5'h14, 32'h0);

    wr(5'h04, 32'h0001_1234);
    check("out_pin_o", pin_o, 32'h1234);
    rd(5'h04, 32'h0000_1234);

    wr(5'h0C, 32'h8);
    wr(5'h08, 32'h8);
    rd(5'h08, 32'h8);
    rd(5'h0C, 32'h8);

    // A 3-cycle glitch on bit 5 is seen by at most one tick.
    pin[5] = 1'b1; step(3); pin[5] = 1'b0;
    step(16);
    rd(5'h00, 32'h0);

    // Rising edge on bit 3: irq_o goes high exactly one cycle after deb changes.
    c = cyc; pin[3] = 1'b1; t2 = accept_cycle(c);
    while (cyc < t2) step(1);
    check("rise_irq_before", irq, 0);
    step(1);
    check("rise_irq_after", irq, 1);
    rd(5'h14, 32'h8);
    rd(5'h00, 32'h8);

    // Bit 3 falls with IRQ_FALL clear. Bit 1 rises with neither edge enabled.
    pin[3] = 1'b0; pin[1] = 1'b1;
    step(16);
    rd(5'h00, 32'h2);
    rd(5'h14, 32'h8);
    check("fall_irq_held", irq, 1);

    wr(5'h14, 32'h8);
    check("w1c_irq", irq, 0);
    rd(5'h14, 32'h0);

    // Bit 1 becomes pending while masked. Enabling it raises irq_o on the next cycle.
    wr(5'h10, 32'h2);
    pin[1] = 1'b0;
    step(16);
    check("masked_irq", irq, 0);
    rd(5'h14, 32'h2);
    wr(5'h08, 32'hA);
    check("enable_pending_irq", irq, 1);
    wr(5'h0C, 32'h0);
    wr(5'h10, 32'h0);
    rd(5'h14, 32'h2);
    wr(5'h14, 32'h2);
    check("w1c_bit1_irq", irq, 0);
    wr(5'h0C, 32'h8);
    rd(5'h10, 32'h0);

    // Set-wins race: W1C of bit 3 in the same cycle a new rise is accepted.
    c = cyc; pin[3] = 1'b1; t2 = accept_cycle(c);
    while (cyc < t2) step(1);
    wr(5'h14, 32'h8);
    check("race_irq", irq, 1);
    rd(5'h14, 32'h8);

    rd(5'h1C, 32'h0);
    wr(5'h18, 32'hFFFF_FFFF);
    rd(5'h18, 32'h0);
    rd(5'h04, 32'h0000_1234);

    // Reset in the same cycle as a write request: no ack, and every register returns to its reset value.
    rst = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 5'h04; bus.wdata = 32'hFFFF;
    step(1);
    rst = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    check("midrst_ack", bus.ack, 0);
    check("midrst_pin_o", pin_o, 32'hA5A5);
    check("midrst_irq", irq, 0);
    rd(5'h00, 32'h0);
    rd(5'h14, 32'h0);
    rd(5'h08, 32'h0);
    rd(5'h0C, 32'h0);
    rd(5'h10, 32'h0);
    rd(5'h04, 32'h0000_A5A5);

    step(3);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised, bus-mapped board I/O controller for the sigma SoC. Successor to the fixed switch/LED/button wiring at board top level.
- Synchronises and debounces IN_W switch/button inputs and drives OUT_W LED outputs from a register.
- Raises a level interrupt on per-bit rising and/or falling edges of the debounced inputs.
- Sits between the board pins and the sigma peripheral bus. One instance per board top.

Parameters:
- IN_W, 16, number of input pins (1..32)
- OUT_W, 16, number of output pins (1..32)
- SYNC_STAGES, 2, synchroniser flops per input (>=2)
- DEB_CYCLES, 65536, clock cycles between debounce sample ticks (>=2)
- OUT_RST, 0, reset value of OUT_DATA (OUT_W bits)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- pin_i  in  IN_W  raw asynchronous board inputs
- pin_o  out  OUT_W  output pins, driven from OUT_DATA
- bus_req_i  in  1  bus request strobe
- bus_we_i  in  1  1 = write, 0 = read
- bus_addr_i  in  5  byte address; bits [1:0] ignored
- bus_wdata_i  in  32  write data
- bus_ack_o  out  1  one-cycle acknowledge
- bus_rdata_o  out  32  read data, valid when bus_ack_o=1
- irq_o  out  1  level interrupt

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: all state is cleared on a clk_i edge while rst_i=1.
- Reset values:
  - pin_o = OUT_RST; bus_ack_o = 0; bus_rdata_o = 0; irq_o = 0.
  - Sync chain, debounced value deb, previous sample prv, prescaler, IRQ_EN, IRQ_RISE, IRQ_FALL and IRQ_PEND are all 0.
- Input path:
  - pin_i passes through SYNC_STAGES flops to give s.
  - Prescaler counts 0..DEB_CYCLES-1 and wraps. tick=1 for one cycle when the count equals DEB_CYCLES-1.
  - On tick: prv <= s. For each bit i where s[i]==prv[i], deb[i] <= s[i].
  - A change is therefore accepted after two consecutive equal samples. Bounces shorter than one tick period are rejected.
- Edge detection:
  - rise = deb_next & ~deb; fall = ~deb_next & deb.
  - pend_set = (rise & IRQ_RISE) | (fall & IRQ_FALL).
  - IRQ_PEND bits are sticky until cleared.
- irq_o = |(IRQ_PEND & IRQ_EN), registered. irq_o follows a pend_set cycle by exactly 1 cycle.
- Register map (word-addressed; fields are IN_W or OUT_W wide, zero-extended on read, upper write bits ignored):
  - 0x00 IN_DATA: read-only deb.
  - 0x04 OUT_DATA: RW, drives pin_o directly from the register.
  - 0x08 IRQ_EN: RW.
  - 0x0C IRQ_RISE: RW.
  - 0x10 IRQ_FALL: RW.
  - 0x14 IRQ_PEND: read returns pending bits; write-1-to-clear.
  - 0x18..0x1C: unmapped. Reads return 0, writes are ignored, ack is still given.
- Bus handshake:
  - bus_req_i=1 in cycle N produces bus_ack_o=1 and bus_rdata_o in cycle N+1.
  - Writes take effect at the cycle N edge, so pin_o changes in cycle N+1.
  - Back-to-back requests are legal every cycle. bus_rdata_o = 0 when no ack is given.
- Boundary conditions:
  - W1C to IRQ_PEND in the same cycle as pend_set on the same bit: the bit remains set (set wins).
  - Edges on bits with both IRQ_RISE and IRQ_FALL clear do not pend.
  - Enabling IRQ_EN on an already-pending bit asserts irq_o on the next cycle.
  - Writing IRQ_RISE/IRQ_FALL never clears existing pending bits.
  - Prescaler wrap is free-running and unaffected by bus traffic.
  - rst_i asserted mid-debounce or mid-transaction: state is cleared and no ack is issued in the following cycle.

Test Plan:
- Reset behaviour (OUT_RST=16'hA5A5): hold rst_i 3 cycles -> pin_o=16'hA5A5, irq_o=0, bus_ack_o=0; read 0x00 -> 0.
- Output register: write 0x04=32'h0001_1234 in cycle N -> ack in N+1, pin_o=16'h1234 in N+1; read back -> 32'h0000_1234.
- Debounce acceptance (DEB_CYCLES=4): pin_i[3] held 0->1 -> IN_DATA[3]=1 after 2 ticks plus sync latency (<= 2+8 cycles). A 3-cycle pulse on pin_i[5] never appears in IN_DATA.
- Rising-edge interrupt: IRQ_RISE=0x8, IRQ_EN=0x8; pin_i[3] rises -> IRQ_PEND=0x8, irq_o=1 one cycle after deb change. Falling edge adds no pend bit. Write 0x14=0x8 -> irq_o=0.
- Set-wins race: W1C bit 3 in the exact cycle a new rise on bit 3 is accepted -> IRQ_PEND[3] stays 1 and irq_o stays 1.
- Unmapped access and mid-op reset: read 0x1C -> ack with 0. Assert rst_i in the same cycle as bus_req_i -> no ack next cycle and all registers at their reset values.
